// File: rtl/axi4l_mem_master.sv
// axi4l_mem_master: single-outstanding AXI4-Lite master with lane steering, load extension and a fatal watchdog
module axi4l_mem_master #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          TIMEOUT = 255,
  parameter logic [2:0]  PROT    = 3'b000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] ARaddr,
  output logic              ARvalid,
  input  logic              ARready,
  output logic [2:0]        ARprot,
  input  logic [DATA_W-1:0] Rdata,
  input  logic [1:0]        Rresp,
  input  logic              Rvalid,
  output logic              Rready,
  output logic [ADDR_W-1:0] AWaddr,
  output logic              AWvalid,
  input  logic              AWready,
  output logic [2:0]        AWprot,
  output logic [DATA_W-1:0] Wdata,
  output logic [DATA_W/8-1:0] Wstrb,
  output logic              Wvalid,
  input  logic              Wready,
  input  logic [1:0]        Bresp,
  input  logic              Bvalid,
  output logic              Bready
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP, FATAL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LB-1:0] lane;
  logic [1:0] size_q;
  logic sgn_q;
  logic [LB-1:0] req_lane;
  logic mis, wait_st, w_done, hs, to;
  logic [DATA_W-1:0] sh, up, ext;
  logic signed [DATA_W-1:0] ups, ext_s;
  logic [6:0] sa;
  assign ARprot = PROT;
  assign AWprot = PROT;
  assign req_lane = req_addr[LB-1:0];
  assign mis = |(req_addr[2:0] & 3'((1 << req_size) - 1)) || (DATA_W == 32 && req_size == 2'd3);
  assign wait_st = state inside {RADDR, RDATA, WRITE, WRESP};
  assign w_done = (!AWvalid || AWready) && (!Wvalid || Wready);
  assign hs = state == RADDR ? ARready : state == RDATA ? Rvalid : state == WRITE ? w_done : Bvalid;
  assign to = TIMEOUT != 0 && wait_st && !hs && cnt == CW'(TIMEOUT - 1);
  // shift the lane down, push the wanted bytes to the top, then shift back to extend
  always_comb begin
    sh = Rdata >> {lane, 3'b000};
    sa = 7'(DATA_W - (8 << size_q));
    up = sh << sa;
    ups = up;
    ext_s = ups >>> sa;
    ext = sgn_q ? ext_s : up >> sa;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= '0;
      ARaddr <= '0;
      ARvalid <= 1'b0;
      Rready <= 1'b0;
      AWaddr <= '0;
      AWvalid <= 1'b0;
      Wdata <= '0;
      Wstrb <= '0;
      Wvalid <= 1'b0;
      Bready <= 1'b0;
      lane <= '0;
      size_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      cnt <= wait_st ? cnt + 1'b1 : '0;
      if (to) begin
        ARvalid <= 1'b0;
        Rready <= 1'b0;
        AWvalid <= 1'b0;
        Wvalid <= 1'b0;
        Bready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err <= 2'd3;
        rsp_rdata <= '0;
        cnt <= '0;
        state <= FATAL;
      end else case (state)
        IDLE:
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lane <= req_lane;
            size_q <= req_size;
            sgn_q <= req_signed;
            ARaddr <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            AWaddr <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            Wdata <= req_wdata << {req_lane, 3'b000};
            Wstrb <= NB'(((1 << (1 << req_size)) - 1) << req_lane);
            rsp_rdata <= '0;
            rsp_err <= mis ? 2'd1 : 2'd0;
            if (mis) begin
              rsp_valid <= 1'b1;
              state <= RESP;
            end else if (req_we) begin
              AWvalid <= 1'b1;
              Wvalid <= 1'b1;
              state <= WRITE;
            end else begin
              ARvalid <= 1'b1;
              state <= RADDR;
            end
          end else req_ready <= 1'b1;
        RADDR:
          if (ARready) begin
            ARvalid <= 1'b0;
            Rready <= 1'b1;
            cnt <= '0;
            state <= RDATA;
          end
        RDATA:
          if (Rvalid) begin
            Rready <= 1'b0;
            rsp_err <= Rresp[1] ? 2'd2 : 2'd0;
            rsp_rdata <= Rresp[1] ? '0 : ext;
            cnt <= '0;
            state <= RESP;
          end
        WRITE: begin
          if (AWready) AWvalid <= 1'b0;
          if (Wready) Wvalid <= 1'b0;
          if (w_done) begin
            Bready <= 1'b1;
            cnt <= '0;
            state <= WRESP;
          end
        end
        WRESP:
          if (Bvalid) begin
            Bready <= 1'b0;
            rsp_err <= Bresp[1] ? 2'd2 : 2'd0;
            rsp_rdata <= '0;
            cnt <= '0;
            state <= RESP;
          end
        RESP:
          if (rsp_valid) begin
            req_ready <= 1'b1;
            state <= IDLE;
          end else rsp_valid <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_axi4l_mem_master.sv
// tb_axi4l_mem_master: directed vector table plus handshake, reset and watchdog sequences for 32- and 64-bit masters
module tb_axi4l_mem_master;
  logic clk = 1'b0, rstn = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, Rdata = '0;
  logic ARready = 1'b0, Rvalid = 1'b0, AWready = 1'b0, Wready = 1'b0, Bvalid = 1'b0;
  logic [1:0] Rresp = '0, Bresp = '0;
  logic a_req_ready, a_rsp_valid, a_ARvalid, a_Rready, a_AWvalid, a_Wvalid, a_Bready;
  logic [31:0] a_rsp_rdata, a_ARaddr, a_AWaddr, a_Wdata;
  logic [1:0] a_rsp_err;
  logic [2:0] a_ARprot, a_AWprot;
  logic [3:0] a_Wstrb;
  logic b_req_ready, b_rsp_valid, b_ARvalid, b_Rready, b_AWvalid, b_Wvalid, b_Bready;
  logic [63:0] b_rsp_rdata, b_Wdata;
  logic [31:0] b_ARaddr, b_AWaddr;
  logic [1:0] b_rsp_err;
  logic [2:0] b_ARprot, b_AWprot;
  logic [7:0] b_Wstrb;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  axi4l_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u32 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .ARaddr(a_ARaddr), .ARvalid(a_ARvalid), .ARready(ARready), .ARprot(a_ARprot),
    .Rdata(Rdata[31:0]), .Rresp(Rresp), .Rvalid(Rvalid), .Rready(a_Rready),
    .AWaddr(a_AWaddr), .AWvalid(a_AWvalid), .AWready(AWready), .AWprot(a_AWprot),
    .Wdata(a_Wdata), .Wstrb(a_Wstrb), .Wvalid(a_Wvalid), .Wready(Wready),
    .Bresp(Bresp), .Bvalid(Bvalid), .Bready(a_Bready));
  axi4l_mem_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) u64 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .ARaddr(b_ARaddr), .ARvalid(b_ARvalid), .ARready(ARready), .ARprot(b_ARprot),
    .Rdata(Rdata), .Rresp(Rresp), .Rvalid(Rvalid), .Rready(b_Rready),
    .AWaddr(b_AWaddr), .AWvalid(b_AWvalid), .AWready(AWready), .AWprot(b_AWprot),
    .Wdata(b_Wdata), .Wstrb(b_Wstrb), .Wvalid(b_Wvalid), .Wready(Wready),
    .Bresp(Bresp), .Bvalid(Bvalid), .Bready(b_Bready));
  logic m_req_ready, m_rsp_valid, m_ARvalid, m_Rready, m_AWvalid, m_Wvalid, m_Bready;
  logic [63:0] m_rsp_rdata, m_Wdata;
  logic [31:0] m_ARaddr, m_AWaddr;
  logic [1:0] m_rsp_err;
  logic [7:0] m_Wstrb;
  logic [5:0] m_prot;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_rdata = sel ? b_rsp_rdata : {32'h0, a_rsp_rdata};
  assign m_rsp_err = sel ? b_rsp_err : a_rsp_err;
  assign m_ARaddr = sel ? b_ARaddr : a_ARaddr;
  assign m_ARvalid = sel ? b_ARvalid : a_ARvalid;
  assign m_Rready = sel ? b_Rready : a_Rready;
  assign m_AWaddr = sel ? b_AWaddr : a_AWaddr;
  assign m_AWvalid = sel ? b_AWvalid : a_AWvalid;
  assign m_Wdata = sel ? b_Wdata : {32'h0, a_Wdata};
  assign m_Wstrb = sel ? b_Wstrb : {4'h0, a_Wstrb};
  assign m_Wvalid = sel ? b_Wvalid : a_Wvalid;
  assign m_Bready = sel ? b_Bready : a_Bready;
  assign m_prot = sel ? {b_ARprot, b_AWprot} : {a_ARprot, a_AWprot};
  typedef struct {
    logic s64; logic we; logic [1:0] size; logic sgn; logic [31:0] addr; logic [63:0] wdata, rdata;
    logic [1:0] resp; logic [31:0] xaddr; logic [63:0] xwdata; logic [7:0] xstrb; logic [63:0] xrdata; logic [1:0] xerr;
  } vec_t;
  vec_t vt[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic slave_idle();
    ARready = 0; Rvalid = 0; AWready = 0; Wready = 0; Bvalid = 0; Rresp = 0; Bresp = 0;
  endtask
  task automatic issue(input logic s, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [63:0] wd);
    sel = s; req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd; req_valid = 1;
  endtask
  task automatic run(input vec_t v);
    int n; logic got, busy;
    sel = v.s64;
    @(negedge clk);
    chk("req_ready before accept", m_req_ready, 1);
    issue(v.s64, v.we, v.size, v.sgn, v.addr, v.wdata);
    ARready = 1; Rvalid = 1; Rdata = v.rdata; Rresp = v.resp;
    AWready = 1; Wready = 1; Bvalid = 1; Bresp = v.resp;
    @(negedge clk);
    req_valid = 0;
    n = 1; got = 0; busy = 0;
    while (!got && n <= 12) begin
      if (m_ARvalid) begin busy = 1; chk("ARaddr", m_ARaddr, v.xaddr); end
      if (m_AWvalid) begin busy = 1; chk("AWaddr", m_AWaddr, v.xaddr); end
      if (m_Wvalid) begin busy = 1; chk("Wdata", m_Wdata, v.xwdata); chk("Wstrb", m_Wstrb, v.xstrb); end
      if (m_rsp_valid) begin
        got = 1;
        chk("rsp_rdata", m_rsp_rdata, v.xrdata);
        chk("rsp_err", m_rsp_err, v.xerr);
        chk("latency", n, v.xerr == 1 ? 1 : 4);
      end else begin
        n++;
        @(negedge clk);
      end
    end
    chk("rsp_valid seen", got, 1);
    chk("axi activity", busy, v.xerr != 1);
    slave_idle();
    @(negedge clk);
    chk("rsp_valid single pulse", m_rsp_valid, 0);
    chk("req_ready after rsp", m_req_ready, 1);
  endtask
  task automatic stagger(input int aw_d, input int w_d);
    int mx, pulses;
    mx = aw_d > w_d ? aw_d : w_d;
    pulses = 0;
    sel = 0;
    @(negedge clk);
    issue(0, 1, 1, 0, 32'h202, 64'h1234);
    slave_idle();
    @(negedge clk);
    req_valid = 0;
    for (int m = 1; m <= mx + 8; m++) begin
      if (m <= mx + 1) begin
        chk("stagger AWvalid", m_AWvalid, m <= aw_d);
        chk("stagger Wvalid", m_Wvalid, m <= w_d);
        chk("stagger Bready", m_Bready, m > mx);
      end
      if (m == 1) begin
        chk("stagger AWaddr", m_AWaddr, 32'h200);
        chk("stagger Wdata", m_Wdata, 64'h12340000);
        chk("stagger Wstrb", m_Wstrb, 8'b1100);
      end
      if (m_rsp_valid) begin pulses++; chk("stagger rsp_err", m_rsp_err, 0); end
      AWready = m >= aw_d; Wready = m >= w_d; Bvalid = m_Bready;
      @(negedge clk);
    end
    chk("stagger rsp pulses", pulses, 1);
    slave_idle();
  endtask
  initial begin
    vt.push_back('{0,0,0,1,'h103,0,'h80AABBCC,0,'h100,0,0,'hFFFFFF80,0});
    vt.push_back('{0,0,0,0,'h101,0,'h1122F344,0,'h100,0,0,'hF3,0});
    vt.push_back('{0,0,1,1,'h202,0,'h9ABC5678,0,'h200,0,0,'hFFFF9ABC,0});
    vt.push_back('{0,0,1,1,'h200,0,'h9ABC5678,0,'h200,0,0,'h5678,0});
    vt.push_back('{0,0,2,0,'h104,0,'hDEADBEEF,0,'h104,0,0,'hDEADBEEF,0});
    vt.push_back('{0,0,2,0,'h101,0,'hDEADBEEF,0,0,0,0,0,1});
    vt.push_back('{0,0,1,0,'h103,0,'hDEADBEEF,0,0,0,0,0,1});
    vt.push_back('{0,0,3,0,'h100,0,'hDEADBEEF,0,0,0,0,0,1});
    vt.push_back('{0,0,2,0,'h10,0,'h12345678,2,'h10,0,0,0,2});
    vt.push_back('{0,0,2,0,'h14,0,'h12345678,1,'h14,0,0,'h12345678,0});
    vt.push_back('{0,1,1,0,'h202,'h1234,0,0,'h200,'h12340000,'hC,0,0});
    vt.push_back('{0,1,0,0,'h301,'hAB,0,0,'h300,'hAB00,'h2,0,0});
    vt.push_back('{0,1,2,0,'h300,'hCAFEF00D,0,0,'h300,'hCAFEF00D,'hF,0,0});
    vt.push_back('{0,1,2,0,'h304,'h1,0,3,'h304,'h1,'hF,0,2});
    vt.push_back('{0,1,1,0,'h301,'h1234,0,0,0,0,0,0,1});
    vt.push_back('{1,0,3,0,'h8,0,'h1122334455667788,2,'h8,0,0,0,2});
    vt.push_back('{1,0,2,1,'hC,0,'h8000000000000000,0,'h8,0,0,'hFFFFFFFF80000000,0});
    vt.push_back('{1,1,0,0,'hF,'h5A,0,0,'h8,'h5A00000000000000,'h80,0,0});
    vt.push_back('{1,0,3,0,'h10,0,'hFEDCBA9876543210,0,'h10,0,0,'hFEDCBA9876543210,0});
    vt.push_back('{1,0,3,0,'hC,0,'hFEDCBA9876543210,0,0,0,0,0,1});
    vt.push_back('{1,0,1,1,'h16,0,'h8001000000000000,0,'h10,0,0,'hFFFFFFFFFFFF8001,0});
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset ARvalid", m_ARvalid, 0);
      chk("reset AWvalid/Wvalid", {m_AWvalid, m_Wvalid}, 0);
      chk("reset Rready/Bready", {m_Rready, m_Bready}, 0);
      chk("reset rsp_valid", m_rsp_valid, 0);
      chk("prot", m_prot, 0);
    end
    sel = 0;
    @(negedge clk);
    rstn = 1;
    foreach (vt[i]) run(vt[i]);
    stagger(1, 4);
    stagger(3, 1);
    stagger(2, 2);
    sel = 0;
    @(negedge clk);
    issue(0, 0, 2, 0, 32'h40, 0);
    ARready = 1;
    @(negedge clk);
    req_valid = 0;
    chk("rd reset ARvalid", m_ARvalid, 1);
    @(negedge clk);
    chk("rd reset Rready before", m_Rready, 1);
    rstn = 0;
    #1;
    chk("rd reset Rready async", m_Rready, 0);
    chk("rd reset req_ready", m_req_ready, 0);
    Rvalid = 1;
    @(negedge clk);
    rstn = 1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      chk("rd reset no rsp", m_rsp_valid, 0);
    end
    chk("rd reset req_ready after", m_req_ready, 1);
    slave_idle();
    @(negedge clk);
    issue(0, 0, 2, 0, 32'h40, 0);
    @(negedge clk);
    req_valid = 0;
    for (int m = 1; m <= 12; m++) begin
      chk("timeout ARvalid", m_ARvalid, m <= 8);
      chk("timeout rsp_valid", m_rsp_valid, m == 9);
      if (m == 9) chk("timeout rsp_err", m_rsp_err, 3);
      @(negedge clk);
    end
    issue(0, 0, 2, 0, 32'h40, 0);
    ARready = 1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      chk("fatal req_ready", m_req_ready, 0);
      chk("fatal ARvalid", m_ARvalid, 0);
      chk("fatal rsp_valid", m_rsp_valid, 0);
    end
    req_valid = 0;
    slave_idle();
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("post fatal req_ready", m_req_ready, 1);
    run(vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
